// File: rtl/player_state_ctrl_pkg.sv
// Shared game constants: player FSM state encoding and a saturating frame-counter helper.
package player_state_ctrl_pkg;

  localparam logic [1:0] PLAY     = 2'd0;
  localparam logic [1:0] HURT     = 2'd1;
  localparam logic [1:0] GAMEOVER = 2'd2;
  localparam logic [1:0] RESTART  = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/player_state_ctrl_vsync_edge.sv
// Turns the level vsync from the VGA timing block into a one-clock frame tick.
module vsync_edge (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic frame_tick
);

  logic r_prev_vsync;

  always_ff @(posedge clk) begin
    if (reset) r_prev_vsync <= 1'b0;
    else       r_prev_vsync <= vsync;
  end

  assign frame_tick = vsync & ~r_prev_vsync;

endmodule

// File: rtl/player_state_ctrl.sv
// Player life-cycle FSM: post-hit blink/invincibility window, timed game-over screen and restart pulse.
// state    | meaning
// PLAY     | normal play, sprite shown, hits accepted
// HURT     | blink window after a hit, invincible
// GAMEOVER | game-over screen held for GameOverFrames frames
// RESTART  | one-cycle restart pulse, then back to PLAY
module player_state_ctrl
  import player_state_ctrl_pkg::*;
#(
  parameter logic [7:0] BlinkFrames    = 8'd60,
  parameter logic [7:0] BlinkHalf      = 8'd4,
  parameter logic [7:0] GameOverFrames = 8'd180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       PlayerHurt,
  input  logic [1:0] playerLives,
  output logic       player_visible,
  output logic       invincible,
  output logic       game_over,
  output logic       game_restart
);

  logic [1:0] r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_half, w_half_nxt;
  logic       r_blink_vis, w_blink_vis_nxt;
  logic       w_tick;
  logic [7:0] w_cnt_inc, w_half_inc;
  logic       w_vis_nxt, w_inv_nxt, w_go_nxt, w_rst_nxt;

  vsync_edge u_vsync_edge (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .frame_tick (w_tick)
  );

  assign w_cnt_inc  = sat_inc8(r_cnt);
  assign w_half_inc = sat_inc8(r_half);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= PLAY;
      r_cnt          <= 8'd0;
      r_half         <= 8'd0;
      r_blink_vis    <= 1'b0;
      player_visible <= 1'b1;
      invincible     <= 1'b0;
      game_over      <= 1'b0;
      game_restart   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_half         <= w_half_nxt;
      r_blink_vis    <= w_blink_vis_nxt;
      player_visible <= w_vis_nxt;
      invincible     <= w_inv_nxt;
      game_over      <= w_go_nxt;
      game_restart   <= w_rst_nxt;
    end
  end

  // Any state change reloads the counter with 0, even when a frame tick lands on the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_half_nxt      = r_half;
    w_blink_vis_nxt = r_blink_vis;
    case (r_state)
      PLAY: begin
        w_cnt_nxt       = 8'd0;
        w_half_nxt      = 8'd0;
        w_blink_vis_nxt = 1'b0;
        if (PlayerHurt && playerLives >= 2'd2) w_state_nxt = HURT;
        else if (PlayerHurt || playerLives == 2'd0) w_state_nxt = GAMEOVER;
      end
      HURT: begin
        if (PlayerHurt && playerLives >= 2'd2) begin
          w_cnt_nxt       = 8'd0;
          w_half_nxt      = 8'd0;
          w_blink_vis_nxt = 1'b0;
        end else if (PlayerHurt) begin
          w_state_nxt = GAMEOVER;
          w_cnt_nxt   = 8'd0;
        end else if (w_tick) begin
          if (w_cnt_inc >= BlinkFrames) begin
            w_state_nxt = PLAY;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_half_inc >= BlinkHalf) begin
              w_half_nxt      = 8'd0;
              w_blink_vis_nxt = ~r_blink_vis;
            end else begin
              w_half_nxt = w_half_inc;
            end
          end
        end
      end
      GAMEOVER: begin
        if (w_tick) begin
          if (w_cnt_inc >= GameOverFrames) begin
            w_state_nxt = RESTART;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = PLAY;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with r_state.
  always_comb begin
    w_vis_nxt = 1'b1;
    w_inv_nxt = 1'b0;
    w_go_nxt  = 1'b0;
    w_rst_nxt = 1'b0;
    case (w_state_nxt)
      HURT: begin
        w_vis_nxt = w_blink_vis_nxt;
        w_inv_nxt = 1'b1;
      end
      GAMEOVER: begin
        w_vis_nxt = 1'b0;
        w_inv_nxt = 1'b1;
        w_go_nxt  = 1'b1;
      end
      RESTART: begin
        w_vis_nxt = 1'b0;
        w_inv_nxt = 1'b1;
        w_rst_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_player_state_ctrl.sv
// Randomized bench for player_state_ctrl against a frame-count reference model.
module tb_player_state_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       PlayerHurt = 1'b0;
  logic [1:0] playerLives = 2'd3;
  logic       player_visible, invincible, game_over, game_restart;

  player_state_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .vsync          (vsync),
    .PlayerHurt     (PlayerHurt),
    .playerLives    (playerLives),
    .player_visible (player_visible),
    .invincible     (invincible),
    .game_over      (game_over),
    .game_restart   (game_restart)
  );

  always #5 clk = ~clk;

  localparam int BLINK = 60;
  localparam int HALF  = 4;
  localparam int OVER  = 180;

  typedef enum {M_PLAY, M_BLINK, M_OVER, M_RESTART} mode_t;
  mode_t m_mode = M_PLAY;
  int    m_frames = 0;
  bit    m_prev = 1'b0;
  bit    e_vis = 1'b1, e_inv = 1'b0, e_go = 1'b0, e_rst = 1'b0;

  int  n_vec = 0, n_err = 0, n_pulse = 0;
  int  ph = 0;
  bit  auto_vs = 1'b1;
  bit  last_tick = 1'b0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d want %0d", tag, $time, got, exp);
    end
  endtask

  // Reference: mode plus frames-seen-in-mode; blink visibility derived by division.
  task automatic model_update();
    bit tick;
    tick = vsync && !m_prev;
    if (reset) begin
      m_prev   = 1'b0;
      m_mode   = M_PLAY;
      m_frames = 0;
    end else begin
      m_prev = vsync;
      case (m_mode)
        M_PLAY: begin
          if (PlayerHurt && playerLives >= 2) begin m_mode = M_BLINK; m_frames = 0; end
          else if (PlayerHurt || playerLives == 0) begin m_mode = M_OVER; m_frames = 0; end
        end
        M_BLINK: begin
          if (PlayerHurt && playerLives >= 2) m_frames = 0;
          else if (PlayerHurt) begin m_mode = M_OVER; m_frames = 0; end
          else if (tick) begin
            m_frames++;
            if (m_frames >= BLINK) begin m_mode = M_PLAY; m_frames = 0; end
          end
        end
        M_OVER: begin
          if (tick) begin
            m_frames++;
            if (m_frames >= OVER) begin m_mode = M_RESTART; m_frames = 0; end
          end
        end
        M_RESTART: begin m_mode = M_PLAY; m_frames = 0; end
        default: ;
      endcase
    end
    e_vis = (m_mode == M_PLAY) || (m_mode == M_BLINK && ((m_frames / HALF) % 2) == 1);
    e_inv = (m_mode != M_PLAY);
    e_go  = (m_mode == M_OVER);
    e_rst = (m_mode == M_RESTART);
  endtask

  task automatic step();
    if (auto_vs) begin
      vsync = (ph < 2);
      ph = (ph + 1) % 6;
    end else begin
      vsync = ($urandom_range(0, 2) == 0);
    end
    last_tick = vsync && !m_prev && !reset;
    @(posedge clk);
    model_update();
    #1;
    check_val("player_visible", int'(player_visible), int'(e_vis));
    check_val("invincible",     int'(invincible),     int'(e_inv));
    check_val("game_over",      int'(game_over),      int'(e_go));
    check_val("game_restart",   int'(game_restart),   int'(e_rst));
    if (game_restart) n_pulse++;
    PlayerHurt = 1'b0;
  endtask

  task automatic hit(input logic [1:0] lives);
    PlayerHurt  = 1'b1;
    playerLives = lives;
    step();
  endtask

  task automatic run_ticks(input int n);
    int t = 0;
    int guard = 0;
    while (t < n && guard < 5000) begin
      step();
      if (last_tick) t++;
      guard++;
    end
  endtask

  initial begin
    int cnt, guard, pulses_before;

    repeat (3) step();
    check_val("reset_vis", int'(player_visible), 1);
    check_val("reset_inv", int'(invincible), 0);
    reset = 1'b0;

    run_ticks(5);

    // Single hit: blink window length in frames.
    repeat ($urandom_range(0, 5)) step();
    hit(2'd3);
    check_val("hit_inv_next", int'(invincible), 1);
    check_val("hit_vis_next", int'(player_visible), 0);
    cnt = 0; guard = 0;
    while (invincible && guard < 2000) begin
      step(); if (last_tick) cnt++; guard++;
    end
    check_val("blink_len", cnt, BLINK);

    // Re-hit at frame 30 restarts the window.
    hit(2'd3);
    run_ticks(30);
    hit(2'd2);
    cnt = 0; guard = 0;
    while (invincible && guard < 2000) begin
      step(); if (last_tick) cnt++; guard++;
    end
    check_val("rehit_len", cnt, BLINK);

    // Hit on the same cycle as a frame tick: no double count.
    playerLives = 2'd3;
    guard = 0;
    while (ph != 0 && guard < 10) begin step(); guard++; end
    hit(2'd3);
    check_val("coincident_tick", int'(last_tick), 1);
    cnt = 0; guard = 0;
    while (invincible && guard < 2000) begin
      step(); if (last_tick) cnt++; guard++;
    end
    check_val("coincident_len", cnt, BLINK);

    // Last life: game over for 180 frames, exactly one restart pulse.
    pulses_before = n_pulse;
    hit(2'd1);
    check_val("go_next", int'(game_over), 1);
    cnt = 0; guard = 0;
    while (!game_restart && guard < 3000) begin
      step(); if (last_tick) cnt++; guard++;
    end
    check_val("gameover_len", cnt, OVER);
    step();
    check_val("restart_1cyc", int'(game_restart), 0);
    check_val("play_after", int'(player_visible), 1);
    repeat (20) step();
    check_val("restart_pulses", n_pulse - pulses_before, 1);

    // Reset mid game-over: back to play, no restart pulse.
    pulses_before = n_pulse;
    hit(2'd1);
    run_ticks(100);
    reset = 1'b1;
    step();
    check_val("rst_go", int'(game_over), 0);
    check_val("rst_vis", int'(player_visible), 1);
    reset = 1'b0;
    repeat (30) step();
    check_val("rst_no_pulse", n_pulse - pulses_before, 0);

    // Random traffic.
    playerLives = 2'd3;
    for (int i = 0; i < 4000; i++) begin
      auto_vs = (i < 2000);
      if ($urandom_range(0, 59) == 0) PlayerHurt = 1'b1;
      case ($urandom_range(0, 99))
        0:       playerLives = 2'd0;
        1, 2, 3: playerLives = 2'd1;
        default: playerLives = 2'($urandom_range(2, 3));
      endcase
      reset = ($urandom_range(0, 699) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/player_state_ctrl.md
PLAYER_STATE_CTRL -- requirements
Module: player_state_ctrl

Interface
REQ-001 SHALL have parameter BlinkFrames, default 8'd60: number of frames in the post-hit blink window.
REQ-002 SHALL have parameter BlinkHalf, default 8'd4: frames per visible/invisible half-period while blinking.
REQ-003 SHALL have parameter GameOverFrames, default 8'd180: number of frames the game-over screen is held.
REQ-004 SHALL have port clk  input  1  system clock; all logic sits on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port vsync  input  1  level vsync from the VGA timing block; one rising edge marks one frame.
REQ-007 SHALL have port PlayerHurt  input  1  one-cycle pulse from the hearts controller.
REQ-008 SHALL have port playerLives  input  2  life count from the hearts controller; on the cycle PlayerHurt is high it still holds the pre-decrement value.
REQ-009 SHALL have port player_visible  output  1  sprite enable to the renderer.
REQ-010 SHALL have port invincible  output  1  high while blinking; the collision logic uses it to mask hits.
REQ-011 SHALL have port game_over  output  1  high while the game-over screen is shown.
REQ-012 SHALL have port game_restart  output  1  one-cycle pulse that resets the hearts controller and the game objects.

Function
REQ-013 SHALL detect vsync rising edges internally with a registered previous value; a frame tick is one clk cycle long.
REQ-014 SHALL implement FSM states PLAY, HURT, GAMEOVER and RESTART.
REQ-015 PLAY: player_visible=1, invincible=0, game_over=0; PlayerHurt with playerLives==1 -> GAMEOVER; PlayerHurt with playerLives>=2 -> HURT; playerLives==0 without PlayerHurt -> GAMEOVER.
REQ-016 HURT entry SHALL clear the frame counter and set the blink phase to invisible; invincible=1 throughout HURT.
REQ-017 HURT: each frame tick increments the 8-bit frame counter; player_visible toggles every BlinkHalf ticks, starting invisible.
REQ-018 HURT: when the counter reaches BlinkFrames on a tick -> PLAY with player_visible=1 in the next cycle.
REQ-019 HURT: PlayerHurt with playerLives==1 -> GAMEOVER; PlayerHurt with playerLives>=2 restarts the blink window (counter=0, invisible).
REQ-020 GAMEOVER: player_visible=0, invincible=1, game_over=1; PlayerHurt ignored; counter counts frame ticks; reaching GameOverFrames -> RESTART.
REQ-021 RESTART: game_restart=1 for exactly one cycle, game_over=0, player_visible=0, invincible=1; unconditional -> PLAY next cycle.
REQ-022 A state transition and a frame tick in the same cycle: the transition wins and the counter is loaded with 0, not incremented.
REQ-023 The frame counter SHALL saturate at 8'hFF and never wrap; a parameter value of 0 SHALL expire on the first tick in that state.
REQ-024 Outputs SHALL be registered; each output changes one cycle after the input event that causes it.

Reset
REQ-025 reset SHALL take priority over every other input and act on the next clk edge.
REQ-026 Values after reset: state=PLAY, counter=0, prev_vsync=0, player_visible=1, invincible=0, game_over=0, game_restart=0.
REQ-027 reset asserted in any state, including mid-blink or mid-game-over, SHALL abort that state without producing a game_restart pulse.

Structure
REQ-028 The FSM state encoding (2-bit localparams PLAY=0, HURT=1, GAMEOVER=2, RESTART=3) SHALL live in the shared game-constants package.
REQ-029 Vsync edge detection SHALL be a sub-module vsync_edge (inputs clk, reset, vsync; output 1-cycle frame_tick), reusable by other frame-counted blocks.
REQ-030 The implementation SHALL contain no latches and no combinational path from any input to any output.

Verification
REQ-031 Reset, then 5 frames with no hits -> player_visible=1, invincible=0, game_over=0 throughout.
REQ-032 PlayerHurt with playerLives=3 -> invincible=1 next cycle; player_visible follows 0,1,0,1... in 4-frame halves; PLAY after frame 60.
REQ-033 Second PlayerHurt (playerLives=2) at frame 30 of a blink window -> counter resets; invincible stays high until 60 frames after the second hit.
REQ-034 PlayerHurt with playerLives=1 -> game_over=1 next cycle; game_restart pulses exactly once, 180 frames later, then PLAY.
REQ-035 PlayerHurt coincident with a vsync rising edge -> HURT entered with counter=0; no double count.
REQ-036 reset at frame 100 of GAMEOVER -> PLAY outputs on the next cycle; no game_restart pulse.
